// File: rtl/mcu_mbox_pkg.sv
// rtl/mcu_mbox_pkg.sv - shared types and constants for the MCU mailbox SRAM zeroize controller
//
// Holds the zeroize FSM state encoding, the ECC code word that belongs to an
// all-zero data word, and helpers deriving SRAM depth / address width from size.
package mcu_mbox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ZERO = 2'd1,
        ST_DONE = 2'd2
    } mbox_zero_state_e;

    // ECC encode of 32'h0; written alongside every zero data word.
    localparam logic [6:0] MCU_MBOX_ZERO_ECC = 7'h00;

    function automatic int mbox_sram_depth(input int size_kb);
        return size_kb * 1024 / 4;
    endfunction

    function automatic int mbox_sram_addr_w(input int size_kb);
        return $clog2(size_kb * 1024 / 4);
    endfunction

endpackage

// File: rtl/mcu_mbox_sram_zeroize_ctrl_if.sv
// rtl/mcu_mbox_sram_zeroize_ctrl_if.sv - SRAM request bundle (chip select, write enable, address, data, ECC)
//
// master: drives a request (the controller's SRAM side).
// slave : receives a request (the controller's CSR/host side).
interface mcu_mbox_sram_zeroize_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [6:0]        ecc;

    modport master (output cs, we, addr, wdata, ecc);
    modport slave  (input  cs, we, addr, wdata, ecc);
endinterface

// File: rtl/mcu_mbox_sram_zeroize_ctrl.sv
// rtl/mcu_mbox_sram_zeroize_ctrl.sv - MCU mailbox SRAM zeroize sequencer and port arbiter
//
// On mailbox release (zero_start) the block takes the SRAM port, writes zero
// data with matching ECC over the used word range, pulses zero_done, then
// returns the port to the CSR side. Outside zeroization host requests pass
// straight through with zero latency; while busy they are dropped.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   zero_start        one-cycle pulse on mailbox release
//   mbox_dlen         mailbox DLEN in bytes, sampled with zero_start
//   host   (slave)    CSR-side SRAM request
//   host_gnt          host request forwarded this cycle
//   host_drop         host request seen while busy and discarded
//   sram   (master)   request to the SRAM
//   zero_in_progress  engine owns the SRAM (ZERO or DONE)
//   zero_done         one-cycle completion pulse
//
// Build option: MCU_MBOX_ZEROIZE_DLEN_EN limits zeroization to the DLEN range;
// without it the whole SRAM is always zeroed and mbox_dlen is ignored.
module mcu_mbox_sram_zeroize_ctrl
    import mcu_mbox_pkg::*;
#(
    parameter int MCU_MBOX_SRAM_SIZE_KB = 512
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          zero_start,
    input  logic [31:0]                   mbox_dlen,
    mcu_mbox_sram_zeroize_ctrl_if.slave   host,
    output logic                          host_gnt,
    output logic                          host_drop,
    mcu_mbox_sram_zeroize_ctrl_if.master  sram,
    output logic                          zero_in_progress,
    output logic                          zero_done
);

    localparam int SRAM_DEPTH  = mbox_sram_depth(MCU_MBOX_SRAM_SIZE_KB);
    localparam int SRAM_ADDR_W = mbox_sram_addr_w(MCU_MBOX_SRAM_SIZE_KB);

    mbox_zero_state_e        state;
    logic [SRAM_ADDR_W-1:0]  cnt;
    logic [SRAM_ADDR_W-1:0]  last_idx;
    logic [SRAM_ADDR_W-1:0]  last_idx_d;
    logic                    range_empty;

`ifdef MCU_MBOX_ZEROIZE_DLEN_EN
    // 33-bit ceiling so dlen = 32'hFFFF_FFFF cannot overflow before the clamp.
    logic [32:0] dlen_words;

    always_comb begin
        dlen_words  = ({1'b0, mbox_dlen} + 33'd3) >> 2;
        range_empty = (dlen_words == 33'd0);
        if (dlen_words >= 33'(SRAM_DEPTH)) begin
            last_idx_d = SRAM_ADDR_W'(SRAM_DEPTH - 1);
        end else begin
            last_idx_d = SRAM_ADDR_W'(dlen_words - 33'd1);
        end
    end
`else
    logic unused_dlen;
    assign unused_dlen = ^mbox_dlen;
    assign range_empty = 1'b0;
    assign last_idx_d  = SRAM_ADDR_W'(SRAM_DEPTH - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            last_idx         <= '0;
            zero_in_progress <= 1'b0;
            zero_done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (zero_start) begin
                        cnt              <= '0;
                        last_idx         <= last_idx_d;
                        zero_in_progress <= 1'b1;
                        if (range_empty) begin
                            state     <= ST_DONE;
                            zero_done <= 1'b1;
                        end else begin
                            state <= ST_ZERO;
                        end
                    end
                end
                ST_ZERO: begin
                    // Stopping at last_idx keeps cnt from wrapping at SRAM_DEPTH-1.
                    if (cnt == last_idx) begin
                        state     <= ST_DONE;
                        zero_done <= 1'b1;
                    end else begin
                        cnt <= cnt + SRAM_ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    state            <= ST_IDLE;
                    zero_done        <= 1'b0;
                    zero_in_progress <= 1'b0;
                end
                default: begin
                    state            <= ST_IDLE;
                    zero_done        <= 1'b0;
                    zero_in_progress <= 1'b0;
                end
            endcase
        end
    end

    // Port mux: host pass-through in IDLE; while busy the host is fully
    // isolated and only the zero writes (ZERO state) reach the SRAM.
    always_comb begin
        sram.cs    = host.cs;
        sram.we    = host.we;
        sram.addr  = host.addr;
        sram.wdata = host.wdata;
        sram.ecc   = host.ecc;
        host_gnt   = host.cs;
        host_drop  = 1'b0;
        if (zero_in_progress) begin
            host_gnt   = 1'b0;
            host_drop  = host.cs;
            sram.cs    = 1'b0;
            sram.we    = 1'b0;
            sram.addr  = '0;
            sram.wdata = 32'h0;
            sram.ecc   = 7'h00;
            if (state == ST_ZERO) begin
                sram.cs    = 1'b1;
                sram.we    = 1'b1;
                sram.addr  = cnt;
                sram.ecc   = MCU_MBOX_ZERO_ECC;
            end
        end
    end

endmodule

// File: tb/tb_mcu_mbox_sram_zeroize_ctrl.sv
// tb/tb_mcu_mbox_sram_zeroize_ctrl.sv - self-checking bench for mcu_mbox_sram_zeroize_ctrl (1 KB SRAM)
module tb_mcu_mbox_sram_zeroize_ctrl;

    localparam int KB    = 1;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        zero_start;
    logic [31:0] mbox_dlen;
    logic        host_gnt;
    logic        host_drop;
    logic        zip;
    logic        zdone;

    always #5 clk = ~clk;

    mcu_mbox_sram_zeroize_ctrl_if #(.ADDR_W(AW)) host_if ();
    mcu_mbox_sram_zeroize_ctrl_if #(.ADDR_W(AW)) sram_if ();

    mcu_mbox_sram_zeroize_ctrl #(.MCU_MBOX_SRAM_SIZE_KB(KB)) dut (
        .clk              (clk),
        .rst              (rst),
        .zero_start       (zero_start),
        .mbox_dlen        (mbox_dlen),
        .host             (host_if),
        .host_gnt         (host_gnt),
        .host_drop        (host_drop),
        .sram             (sram_if),
        .zero_in_progress (zip),
        .zero_done        (zdone)
    );

    int              vectors;
    int              miscompares;
    int              cyc;
    int              t_start;
    int              n_words;
    bit              active;
    logic [AW-1:0]   exp_q[$];
    logic [31:0]     mem[DEPTH];

    logic            h_cs;
    logic            h_we;
    logic [AW-1:0]   h_addr;
    logic [31:0]     h_wdata;
    logic [6:0]      h_ecc;

    task automatic host_idle();
        h_cs = 0; h_we = 0; h_addr = '0; h_wdata = '0; h_ecc = '0;
    endtask

    task automatic host_rand();
        h_cs    = 1'($urandom_range(0, 1));
        h_we    = 1'($urandom_range(0, 1));
        h_addr  = AW'($urandom);
        h_wdata = $urandom;
        h_ecc   = 7'($urandom);
    endtask

    task automatic host_w5();
        h_cs = 1; h_we = 1; h_addr = AW'(5); h_wdata = 32'hA5A5_A5A5; h_ecc = 7'h2A;
    endtask

    // Words the zeroize should cover for a given DLEN.
    task automatic plan_words(input logic [31:0] dlen, output int n);
`ifdef MCU_MBOX_ZEROIZE_DLEN_EN
        logic [63:0] w;
        w = ({32'h0, dlen} + 64'd3) >> 2;
        n = (w > 64'(DEPTH)) ? DEPTH : int'(w);
`else
        n = DEPTH;
`endif
        $display("zeroize start dlen=%h words=%0d", dlen, n);
    endtask

    // One clock cycle: drive inputs after negedge, compare outputs, update scoreboard.
    task automatic step(input string tag, input logic zs, input logic [31:0] dl, input logic r);
        logic [52:0]   obs_v;
        logic [52:0]   exp_v;
        logic          e_zip, e_done, e_gnt, e_drop, e_cs, e_we;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_wdata;
        logic [6:0]    e_ecc;
        bit            busy_now;
        int            rel;
        int            n;

        zero_start    = zs;
        mbox_dlen     = dl;
        rst           = r;
        host_if.cs    = h_cs;
        host_if.we    = h_we;
        host_if.addr  = h_addr;
        host_if.wdata = h_wdata;
        host_if.ecc   = h_ecc;
        #1;

        busy_now = active;
        e_zip = 0; e_done = 0; e_gnt = h_cs; e_drop = 0;
        e_cs = h_cs; e_we = h_we; e_addr = h_addr; e_wdata = h_wdata; e_ecc = h_ecc;
        if (active) begin
            rel = cyc - t_start;
            if (rel >= 1 && rel <= n_words) begin
                e_zip = 1; e_gnt = 0; e_drop = h_cs;
                e_cs = 1; e_we = 1; e_wdata = 32'h0; e_ecc = 7'h00;
                e_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            end else if (rel == n_words + 1) begin
                e_zip = 1; e_done = 1; e_gnt = 0; e_drop = h_cs;
                e_cs = 0; e_we = 0; e_addr = '0; e_wdata = 32'h0; e_ecc = 7'h00;
                active = 0;
            end
        end
        exp_v = {e_zip, e_done, e_gnt, e_drop, e_cs, e_we, e_addr, e_wdata, e_ecc};
        obs_v = {zip, zdone, host_gnt, host_drop, sram_if.cs, sram_if.we,
                 sram_if.addr, sram_if.wdata, sram_if.ecc};
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs_v, exp_v);
        end

        if (sram_if.cs === 1'b1 && sram_if.we === 1'b1) mem[sram_if.addr] = sram_if.wdata;

        if (r) begin
            active = 0;
            exp_q.delete();
        end else if (zs && !busy_now) begin
            plan_words(dl, n);
            n_words = n;
            t_start = cyc;
            active  = 1;
            for (int i = 0; i < n; i++) exp_q.push_back(AW'(i));
        end

        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input string tag, input bit rnd);
        int g;
        g = 0;
        while (active && g < 600) begin
            if (rnd) host_rand();
            step(tag, 0, 32'h0, 0);
            g++;
        end
        vectors++;
        assert (!active && exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL %s_drain observed=active:%0d left:%0d expected=active:0 left:0", tag, active, exp_q.size());
        end
    endtask

    task automatic check_mem5(input string tag, input logic [31:0] expv);
        vectors++;
        assert (mem[5] === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, mem[5], expv);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; t_start = 0; n_words = 0; active = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_BEEF;
        host_idle();
        rst = 1; zero_start = 0; mbox_dlen = '0;
        host_if.cs = 0; host_if.we = 0; host_if.addr = '0; host_if.wdata = '0; host_if.ecc = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state and zero-latency pass-through
        step("reset", 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            host_rand();
            step("pass", 0, 32'h0, 0);
        end

        // Whole-range zeroize (clamped when DLEN-limited) with random host traffic
        host_rand();
        step("start_full", 1, 32'hFFFF_FFFF, 0);
        drain("full", 1);

        // Short range, zero_start re-pulsed at T+3 is ignored
        host_idle();
        step("start10", 1, 32'd10, 0);
        step("z10", 0, 32'h0, 0);
        step("z10", 0, 32'h0, 0);
        step("repulse", 1, 32'd40, 0);
        drain("dlen10", 0);

        // Empty range
        step("start0", 1, 32'd0, 0);
        drain("dlen0", 0);

        // Host write to addr 5 every cycle across a zeroize
        host_w5();
        mem[5] = 32'h0;
        step("hostw_pre", 0, 32'h0, 0);
        check_mem5("hostw_pre_mem5", 32'hA5A5_A5A5);
        step("hostw_start", 1, 32'd64, 0);
        check_mem5("hostw_same_cycle_mem5", 32'hA5A5_A5A5);
        drain("hostw", 0);
        check_mem5("hostw_zeroed_mem5", 32'h0);
        step("hostw_after", 0, 32'h0, 0);
        check_mem5("hostw_after_mem5", 32'hA5A5_A5A5);

        // Reset at T+50 of a full-range zeroize
        host_idle();
        step("start_rst", 1, 32'hFFFF_FFFF, 0);
        for (int i = 0; i < 49; i++) step("pre_rst", 0, 32'h0, 0);
        step("rst_mid", 0, 32'h0, 1);
        for (int i = 0; i < 6; i++) step("post_rst", 0, 32'h0, 0);
        host_rand();
        step("post_rst_pass", 0, 32'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
